// File: rtl/ce_pulse_gen.sv
// Push-button conditioner: 2-flop synchroniser, tick prescaler, tick-based
// debouncer and hold/auto-repeat FSM producing single-cycle CE pulses.
module ce_pulse_gen #(
  parameter int unsigned DIV          = 50000,
  parameter int unsigned DEB_TICKS    = 10,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic Clk,
  input  logic Rn,
  input  logic Btn,
  input  logic En,
  output logic CE,
  output logic Level,
  output logic Tick,
  output logic Repeating
);

  localparam int unsigned PW   = $clog2(DIV);
  localparam int unsigned DW   = $clog2(DEB_TICKS + 1);
  localparam int unsigned HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned HW   = $clog2(HMAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [1:0]    sync_q;
  logic          btn_s;
  logic [PW-1:0] pre_q;
  logic [DW-1:0] deb_q;
  state_t        state_q, state_n;
  logic [HW-1:0] hcnt_q, hcnt_n;
  logic          pulse_c;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge Clk) begin
    if (!Rn) sync_q <= '0;
    else     sync_q <= {sync_q[0], Btn};
  end

  assign btn_s = sync_q[1];

  // Free-running prescaler; Tick is registered one count early so it lines up with DIV-1
  always_ff @(posedge Clk) begin
    if (!Rn) begin
      pre_q <= '0;
      Tick  <= 1'b0;
    end else begin
      pre_q <= (pre_q == PW'(DIV - 1)) ? '0 : pre_q + PW'(1);
      Tick  <= (pre_q == PW'(DIV - 2));
    end
  end

  // Debouncer: Level flips after DEB_TICKS consecutive ticks of disagreement
  always_ff @(posedge Clk) begin
    if (!Rn) begin
      deb_q <= '0;
      Level <= 1'b0;
    end else if (btn_s == Level) begin
      deb_q <= '0;
    end else if (Tick) begin
      if (deb_q == DW'(DEB_TICKS - 1)) begin
        deb_q <= '0;
        Level <= ~Level;
      end else begin
        deb_q <= deb_q + DW'(1);
      end
    end
  end

  // FSM state, hold/repeat counter and registered outputs
  always_ff @(posedge Clk) begin
    if (!Rn) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      CE        <= 1'b0;
      Repeating <= 1'b0;
    end else begin
      state_q   <= state_n;
      hcnt_q    <= hcnt_n;
      CE        <= pulse_c & En;
      Repeating <= (state_n == REPEAT);
    end
  end

  // Next-state and pulse decision; release always takes priority over a count match
  always_comb begin
    state_n = state_q;
    hcnt_n  = hcnt_q;
    pulse_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (Level) begin
          pulse_c = 1'b1;
          hcnt_n  = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!Level) begin
          state_n = IDLE;
        end else if (hcnt_q == HW'(HOLD_TICKS)) begin
          if (REPEAT_TICKS != 0) begin
            pulse_c = 1'b1;
            hcnt_n  = '0;
            state_n = REPEAT;
          end
        end else if (Tick) begin
          hcnt_n = hcnt_q + HW'(1);
        end
      end
      REPEAT: begin
        if (!Level) begin
          state_n = IDLE;
        end else if (hcnt_q == HW'(REPEAT_TICKS)) begin
          pulse_c = 1'b1;
          hcnt_n  = '0;
        end else if (Tick) begin
          hcnt_n = hcnt_q + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
